// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl - memory-mapped interrupt controller
//
// Synchronises up to NSRC asynchronous interrupt sources, latches them into a
// pending register (per-source rising-edge or level mode), masks them, and
// presents the lowest-index pending&mask source to the CPU as a registered
// request. The CPU acknowledges with a CLAIM store and finishes with an EOI
// store. After EOI an optional holdoff window keeps irq low for HOLDOFF cycles.
//
// Register window (word offsets from BASE_ADDR):
//   0x00 PENDING  read; store = write-1-to-clear on edge-mode bits
//   0x04 MASK     read/write
//   0x08 EDGE     read/write (1 = rising edge, 0 = level)
//   0x0C CLAIM    write only (wdata[2:0] = id), reads 0
//   0x10 EOI      write only, reads 0
//
// Ports:
//   clk         clock
//   reset       synchronous active-high reset
//   src         asynchronous interrupt sources, active-high
//   bus_addr    CPU data address
//   bus_wdata   CPU store data
//   bus_byteen  store byte enables; a store takes effect only when bit 0 is set
//   bus_rdata   combinational read data for bus_addr
//   irq         registered request to the CPU
//   irq_id      id of the presented source (meaningful while irq=1)
//   busy        high while servicing or in the post-EOI holdoff
// -----------------------------------------------------------------------------
module irq_ctrl #(
  parameter int          NSRC      = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7f40,
  parameter int          HOLDOFF   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic [31:0]     bus_addr,
  input  logic [31:0]     bus_wdata,
  input  logic [3:0]      bus_byteen,
  output logic [31:0]     bus_rdata,
  output logic            irq,
  output logic [2:0]      irq_id,
  output logic            busy
);

  localparam int CW = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF);
  localparam logic [CW-1:0] HOLD_LOAD = (HOLDOFF > 0) ? CW'(HOLDOFF - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  // Registers
  logic [NSRC-1:0] r_s1, r_s2, r_s3;
  logic [NSRC-1:0] r_pending;
  logic [NSRC-1:0] r_mask;
  logic [NSRC-1:0] r_edge_mode;
  state_t          r_state;
  logic [CW-1:0]   r_hold_cnt;
  logic            r_irq;
  logic [2:0]      r_irq_id;
  logic            r_busy;

  // Combinational
  logic [31:0]     w_word;
  logic            w_sel_pend, w_sel_mask, w_sel_edge, w_sel_claim, w_sel_eoi;
  logic            w_store;
  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_active;
  logic            w_any;
  logic [2:0]      w_winner;
  logic [2:0]      w_claim_id;
  logic            w_claim_ok;
  logic            w_eoi_ok;
  logic [NSRC-1:0] w_clr;
  logic [NSRC-1:0] w_pending_next;
  state_t          w_state_next;
  logic [CW-1:0]   w_hold_next;
  logic            w_unused;

  // Address decode on the word address
  assign w_word      = bus_addr & ~32'd3;
  assign w_sel_pend  = (w_word == BASE_ADDR);
  assign w_sel_mask  = (w_word == BASE_ADDR + 32'h4);
  assign w_sel_edge  = (w_word == BASE_ADDR + 32'h8);
  assign w_sel_claim = (w_word == BASE_ADDR + 32'hC);
  assign w_sel_eoi   = (w_word == BASE_ADDR + 32'h10);
  assign w_store     = bus_byteen[0];
  assign w_claim_id  = bus_wdata[2:0];

  // Upper data bits and upper byte enables carry no meaning here
  assign w_unused = &{1'b0, bus_wdata, bus_byteen[3:1]};

  assign w_rise   = r_s2 & ~r_s3;
  assign w_active = r_pending & r_mask;
  assign w_any    = |w_active;

  // Lowest index wins: scan downwards so the last hit is the smallest index
  always_comb begin
    w_winner = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_winner = 3'(i);
      end
    end
  end

  // A claim is honoured only for the source currently being presented, so a
  // claim for another pending source does not steal the handshake.
  assign w_claim_ok = w_store && w_sel_claim && (r_state == ST_ASSERT) &&
                      w_any && (w_claim_id == w_winner);
  assign w_eoi_ok   = w_store && w_sel_eoi && (r_state == ST_SERVICE);

  // Per-source pending update. Edge mode: a rise beats a simultaneous clear.
  // Level mode: the bit simply follows the synchronised input.
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      assign w_clr[gi] = (w_store && w_sel_pend && bus_wdata[gi]) ||
                         (w_claim_ok && (w_winner == 3'(gi)));
      assign w_pending_next[gi] = r_edge_mode[gi]
                                ? (w_rise[gi] | (r_pending[gi] & ~w_clr[gi]))
                                : r_s2[gi];
    end
  endgenerate

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_next = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (!w_any) begin
          w_state_next = ST_IDLE;
        end else if (w_claim_ok) begin
          w_state_next = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (w_eoi_ok) begin
          if (HOLDOFF == 0) begin
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_HOLDOFF;
            w_hold_next  = HOLD_LOAD;
          end
        end
      end
      ST_HOLDOFF: begin
        if (r_hold_cnt == '0) begin
          w_state_next = ST_IDLE;
        end else begin
          w_hold_next = r_hold_cnt - CW'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1        <= '0;
      r_s2        <= '0;
      r_s3        <= '0;
      r_pending   <= '0;
      r_mask      <= '0;
      r_edge_mode <= '1;
      r_state     <= ST_IDLE;
      r_hold_cnt  <= '0;
      r_irq       <= 1'b0;
      r_irq_id    <= 3'd0;
      r_busy      <= 1'b0;
    end else begin
      r_s1      <= src;
      r_s2      <= r_s1;
      r_s3      <= r_s2;
      r_pending <= w_pending_next;
      if (w_store && w_sel_mask) begin
        r_mask <= bus_wdata[NSRC-1:0];
      end
      if (w_store && w_sel_edge) begin
        r_edge_mode <= bus_wdata[NSRC-1:0];
      end
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_next;
      r_irq      <= (w_state_next == ST_ASSERT);
      r_irq_id   <= w_winner;
      r_busy     <= (w_state_next == ST_SERVICE) || (w_state_next == ST_HOLDOFF);
    end
  end

  // Read mux; unused bits and write-only registers read as zero
  always_comb begin
    bus_rdata = 32'd0;
    if (w_sel_pend) begin
      bus_rdata[NSRC-1:0] = r_pending;
    end else if (w_sel_mask) begin
      bus_rdata[NSRC-1:0] = r_mask;
    end else if (w_sel_edge) begin
      bus_rdata[NSRC-1:0] = r_edge_mode;
    end
  end

  assign irq    = r_irq;
  assign irq_id = r_irq_id;
  assign busy   = r_busy;

endmodule

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl - directed self-checking bench for irq_ctrl (default parameters:
// NSRC=6, BASE_ADDR=0x7f40, HOLDOFF=2). Inputs change 1 ns after the rising
// edge; outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_irq_ctrl;

  localparam logic [31:0] BASE      = 32'h0000_7f40;
  localparam logic [7:0]  OFF_PEND  = 8'h00;
  localparam logic [7:0]  OFF_MASK  = 8'h04;
  localparam logic [7:0]  OFF_EDGE  = 8'h08;
  localparam logic [7:0]  OFF_CLAIM = 8'h0C;
  localparam logic [7:0]  OFF_EOI   = 8'h10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  src = '0;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [3:0]  bus_byteen = '0;
  logic [31:0] bus_rdata;
  logic        irq;
  logic [2:0]  irq_id;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  irq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .src        (src),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_byteen (bus_byteen),
    .bus_rdata  (bus_rdata),
    .irq        (irq),
    .irq_id     (irq_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [7:0] off, input logic [31:0] data, input logic [3:0] be);
    bus_addr   = BASE + {24'd0, off};
    bus_wdata  = data;
    bus_byteen = be;
    @(posedge clk);
    #1;
    bus_byteen = 4'd0;
    bus_wdata  = 32'd0;
    $display("wr  off=0x%02h data=0x%08h be=%b -> irq=%0b id=%0d busy=%0b",
             off, data, be, irq, irq_id, busy);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
    bus_addr = BASE + {24'd0, off};
    #1;
    $display("rd  off=0x%02h data=0x%08h", off, bus_rdata);
    check_val(tag, bus_rdata, exp);
  endtask

  task automatic chk_out(input string tag, input logic exp_irq, input logic exp_busy);
    check_val({tag, ".irq"}, {31'd0, irq}, {31'd0, exp_irq});
    check_val({tag, ".busy"}, {31'd0, busy}, {31'd0, exp_busy});
  endtask

  task automatic chk_id(input string tag, input logic [2:0] exp_id);
    check_val(tag, {29'd0, irq_id}, {29'd0, exp_id});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset and register defaults ----------------
    reset = 1'b1;
    tick(3);
    chk_out("in_reset", 1'b0, 1'b0);
    reset = 1'b0;
    tick(1);
    rd_chk("rst_pending", OFF_PEND, 32'h0);
    rd_chk("rst_mask", OFF_MASK, 32'h0);
    rd_chk("rst_edge", OFF_EDGE, 32'h3F);
    chk_out("rst", 1'b0, 1'b0);
    bus_wr(OFF_MASK, 32'h3F, 4'b0000);
    rd_chk("mask_be0", OFF_MASK, 32'h0);
    bus_wr(OFF_MASK, 32'h3F, 4'b1110);
    rd_chk("mask_be_hi", OFF_MASK, 32'h0);
    bus_wr(OFF_CLAIM, 32'h2, 4'b0001);
    rd_chk("claim_reads0", OFF_CLAIM, 32'h0);
    rd_chk("eoi_reads0", OFF_EOI, 32'h0);
    rd_chk("unmapped_reads0", 8'h14, 32'h0);
    chk_out("claim_idle", 1'b0, 1'b0);

    // ---------------- single edge source, full handshake ----------------
    bus_wr(OFF_MASK, 32'h3F, 4'b0001);
    rd_chk("mask_set", OFF_MASK, 32'h3F);
    src = 6'b000100;
    tick(1);                                   // edge N
    src = 6'b000000;
    tick(1);                                   // edge N+1
    rd_chk("p2_n1", OFF_PEND, 32'h0);
    tick(1);                                   // edge N+2
    rd_chk("p2_n2", OFF_PEND, 32'h04);
    chk_out("p2_n2", 1'b0, 1'b0);
    tick(1);                                   // edge N+3
    chk_out("p2_n3", 1'b1, 1'b0);
    chk_id("p2_id", 3'd2);
    bus_wr(OFF_CLAIM, 32'h2, 4'b0001);
    chk_out("p2_claim", 1'b0, 1'b1);
    rd_chk("p2_claim_pend", OFF_PEND, 32'h0);
    tick(2);
    chk_out("p2_service", 1'b0, 1'b1);
    bus_wr(OFF_EOI, 32'h0, 4'b0001);           // edge E
    chk_out("p2_eoi_e0", 1'b0, 1'b1);
    tick(1);
    chk_out("p2_eoi_e1", 1'b0, 1'b1);
    tick(1);
    chk_out("p2_eoi_e2", 1'b0, 1'b0);

    // ---------------- two simultaneous sources ----------------
    src = 6'b010010;
    tick(3);
    rd_chk("p3_pend", OFF_PEND, 32'h12);
    tick(1);
    chk_out("p3_assert", 1'b1, 1'b0);
    chk_id("p3_id1", 3'd1);
    bus_wr(OFF_CLAIM, 32'h4, 4'b0001);
    chk_out("p3_claim4", 1'b1, 1'b0);
    chk_id("p3_id1_keep", 3'd1);
    bus_wr(OFF_CLAIM, 32'h1, 4'b0001);
    chk_out("p3_claim1", 1'b0, 1'b1);
    rd_chk("p3_pend_after", OFF_PEND, 32'h10);
    bus_wr(OFF_EOI, 32'h0, 4'b0001);
    tick(2);
    chk_out("p3_hold_done", 1'b0, 1'b0);
    tick(1);
    chk_out("p3_reassert", 1'b1, 1'b0);
    chk_id("p3_id4", 3'd4);
    bus_wr(OFF_CLAIM, 32'h4, 4'b0001);
    rd_chk("p3_pend_clr", OFF_PEND, 32'h0);
    bus_wr(OFF_EOI, 32'h0, 4'b0001);
    tick(3);
    src = 6'b000000;
    tick(3);
    chk_out("p3_idle", 1'b0, 1'b0);

    // ---------------- level-mode source ----------------
    bus_wr(OFF_EDGE, 32'h37, 4'b0001);
    rd_chk("p4_edge", OFF_EDGE, 32'h37);
    bus_wr(OFF_MASK, 32'h08, 4'b0001);
    src = 6'b001000;
    tick(3);
    rd_chk("p4_pend", OFF_PEND, 32'h08);
    tick(1);
    chk_out("p4_assert", 1'b1, 1'b0);
    chk_id("p4_id3", 3'd3);
    bus_wr(OFF_PEND, 32'h08, 4'b0001);
    rd_chk("p4_w1c_noeffect", OFF_PEND, 32'h08);
    chk_out("p4_w1c", 1'b1, 1'b0);
    bus_wr(OFF_CLAIM, 32'h3, 4'b0001);
    chk_out("p4_claim", 1'b0, 1'b1);
    rd_chk("p4_claim_pend", OFF_PEND, 32'h08);
    bus_wr(OFF_EOI, 32'h0, 4'b0001);
    tick(2);
    chk_out("p4_hold_done", 1'b0, 1'b0);
    tick(1);
    chk_out("p4_reassert", 1'b1, 1'b0);
    chk_id("p4_id3_again", 3'd3);
    src = 6'b000000;
    tick(2);                                   // edges M, M+1
    rd_chk("p4_drop_m1", OFF_PEND, 32'h08);
    tick(1);                                   // edge M+2
    rd_chk("p4_drop_m2", OFF_PEND, 32'h0);
    tick(1);
    chk_out("p4_drop_irq", 1'b0, 1'b0);
    bus_wr(OFF_EDGE, 32'h3F, 4'b0001);

    // ---------------- masking while asserted ----------------
    bus_wr(OFF_MASK, 32'h3F, 4'b0001);
    src = 6'b000001;
    tick(1);
    src = 6'b000000;
    tick(2);
    rd_chk("p5_pend", OFF_PEND, 32'h01);
    tick(1);
    chk_out("p5_assert", 1'b1, 1'b0);
    chk_id("p5_id0", 3'd0);
    bus_wr(OFF_MASK, 32'h0, 4'b0001);
    tick(1);
    chk_out("p5_masked", 1'b0, 1'b0);
    rd_chk("p5_pend_kept", OFF_PEND, 32'h01);
    bus_wr(OFF_MASK, 32'h3F, 4'b0001);
    tick(1);
    chk_out("p5_unmasked", 1'b1, 1'b0);
    chk_id("p5_id0_again", 3'd0);
    bus_wr(OFF_CLAIM, 32'h0, 4'b0001);
    bus_wr(OFF_EOI, 32'h0, 4'b0001);
    tick(3);

    // ---------------- reset during service ----------------
    src = 6'b100000;
    tick(1);
    src = 6'b000000;
    tick(3);
    chk_out("p6_assert", 1'b1, 1'b0);
    chk_id("p6_id5", 3'd5);
    bus_wr(OFF_CLAIM, 32'h5, 4'b0001);
    chk_out("p6_service", 1'b0, 1'b1);
    src = 6'b000010;
    tick(1);
    src = 6'b000000;
    tick(2);
    rd_chk("p6_pend_in_service", OFF_PEND, 32'h02);
    tick(2);
    chk_out("p6_no_nest", 1'b0, 1'b1);
    reset = 1'b1;
    tick(1);
    chk_out("p6_reset", 1'b0, 1'b0);
    rd_chk("p6_reset_pend", OFF_PEND, 32'h0);
    reset = 1'b0;
    rd_chk("p6_reset_mask", OFF_MASK, 32'h0);
    bus_wr(OFF_EOI, 32'h0, 4'b0001);
    chk_out("p6_eoi_ignored", 1'b0, 1'b0);
    tick(2);
    chk_out("p6_eoi_ignored2", 1'b0, 1'b0);

    // ---------------- set/clear collision ----------------
    src = 6'b100000;
    tick(1);                                   // edge N
    src = 6'b000000;
    tick(1);                                   // edge N+1
    bus_wr(OFF_PEND, 32'h20, 4'b0001);         // edge N+2, rise coincides
    rd_chk("p7_set_wins", OFF_PEND, 32'h20);
    bus_wr(OFF_PEND, 32'h20, 4'b0001);
    rd_chk("p7_w1c", OFF_PEND, 32'h0);
    chk_out("p7_final", 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
